// File: rtl/spi_pkg.sv
// Definitions shared by both ends of the word-parallel SPI link:
// state encodings, the SPI mode constants and a constant-friendly clog2.
package spi_pkg;

    // Mode 0: SCLK idles low, data is captured on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_master_parallel.sv
// Word-parallel SPI initiator, mode 0. Host words offered back to back are
// sent as one burst under a single CS assertion, one word per SCLK period.
module spi_master_parallel
    import spi_pkg::*;
#(
    parameter int NB_BITS     = 32,
    parameter int HALF_PERIOD = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_cs,
    output logic               o_SCLK,
    output logic [NB_BITS-1:0] o_MOSI,
    input  logic [NB_BITS-1:0] i_MISO,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_rx_valid,
    output logic               o_busy
);

    localparam int CNT_W = (clog2(HALF_PERIOD) > 0) ? clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               pend;
    logic [NB_BITS-1:0] pend_word;
    logic               last;
    logic               handshake;

    assign last = (cnt == CNT_LAST);

    // Gated by reset so the first accept can only happen after release.
    // A word is taken in IDLE, or during HIGH into the one-deep pend slot.
    assign o_ready   = i_rst & ((state == IDLE) | ((state == HIGH) & ~pend));
    assign handshake = i_valid & o_ready;
    assign o_busy    = (state != IDLE);

    // NOTE: every register uses non-blocking assignment so all decisions in
    // one edge see the pre-edge state; datapath registers are reset as well,
    // so an aborted burst leaves o_MOSI and o_data at a known zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pend       <= 1'b0;
            pend_word  <= '0;
            o_cs       <= 1'b0;
            o_SCLK     <= CPOL;
            o_MOSI     <= '0;
            o_data     <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (i_valid) begin
                        o_MOSI <= i_data;
                        o_cs   <= 1'b1;
                        state  <= LOW;
                    end
                end

                LOW: begin
                    if (last) begin
                        o_SCLK     <= ~CPOL;
                        o_data     <= i_MISO;
                        o_rx_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HIGH: begin
                    if (last) begin
                        o_SCLK <= CPOL;
                        cnt    <= '0;
                        // A word accepted on this very cycle continues the burst too.
                        if (pend || handshake) begin
                            o_MOSI <= pend ? pend_word : i_data;
                            pend   <= 1'b0;
                            state  <= LOW;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (handshake) begin
                            pend_word <= i_data;
                            pend      <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Keeps CS up across the slave's final falling-edge reload.
                    if (last) begin
                        o_cs  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_parallel.sv
// Directed bench for spi_master_parallel: one instance at HALF_PERIOD=4 and
// one at HALF_PERIOD=2, each wired to a behavioural edge-detecting slave.
module tb_spi_master_parallel;

    localparam int NB = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          host_valid;
    logic [NB-1:0] host_data;
    logic          use_hp2;

    logic          valid_a, ready_a, cs_a, sclk_a, rxv_a, busy_a;
    logic [NB-1:0] mosi_a, miso_a, data_a;
    logic          valid_b, ready_b, cs_b, sclk_b, rxv_b, busy_b;
    logic [NB-1:0] mosi_b, miso_b, data_b;

    assign valid_a = host_valid & ~use_hp2;
    assign valid_b = host_valid & use_hp2;

    spi_master_parallel #(.NB_BITS(NB), .HALF_PERIOD(4)) dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_data(host_data), .i_valid(valid_a),
        .o_ready(ready_a), .o_cs(cs_a), .o_SCLK(sclk_a), .o_MOSI(mosi_a),
        .i_MISO(miso_a), .o_data(data_a), .o_rx_valid(rxv_a), .o_busy(busy_a)
    );

    spi_master_parallel #(.NB_BITS(NB), .HALF_PERIOD(2)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_data(host_data), .i_valid(valid_b),
        .o_ready(ready_b), .o_cs(cs_b), .o_SCLK(sclk_b), .o_MOSI(mosi_b),
        .i_MISO(miso_b), .o_data(data_b), .o_rx_valid(rxv_b), .o_busy(busy_b)
    );

    logic          cur_ready, cur_cs, cur_sclk, cur_rxv, cur_busy;
    logic [NB-1:0] cur_mosi, cur_data;
    assign cur_ready = use_hp2 ? ready_b : ready_a;
    assign cur_cs    = use_hp2 ? cs_b    : cs_a;
    assign cur_sclk  = use_hp2 ? sclk_b  : sclk_a;
    assign cur_rxv   = use_hp2 ? rxv_b   : rxv_a;
    assign cur_busy  = use_hp2 ? busy_b  : busy_a;
    assign cur_mosi  = use_hp2 ? mosi_b  : mosi_a;
    assign cur_data  = use_hp2 ? data_b  : data_a;

    logic [NB-1:0] reply [8];
    logic [NB-1:0] tx [8];
    logic [NB-1:0] slave_rx [$];
    logic [NB-1:0] rx_q [$];
    int            rx_cyc [$];

    // Slave model: reloads MISO at CS rise and on each detected SCLK fall,
    // latches MOSI on each detected SCLK rise, drives Z while deselected.
    logic [NB-1:0] smiso_a = '0;
    logic [2:0]    sidx_a = '0;
    logic          scs_d_a = 1'b0;
    logic          ssclk_d_a = 1'b0;
    always @(posedge clk) begin
        if (cs_a && !scs_d_a) begin
            smiso_a <= reply[0];
            sidx_a  <= 3'd1;
        end else if (cs_a && ssclk_d_a && !sclk_a) begin
            smiso_a <= reply[sidx_a];
            sidx_a  <= sidx_a + 3'd1;
        end
        if (cs_a && sclk_a && !ssclk_d_a) slave_rx.push_back(mosi_a);
        scs_d_a   <= cs_a;
        ssclk_d_a <= sclk_a;
    end
    assign miso_a = cs_a ? smiso_a : 'z;

    logic [NB-1:0] smiso_b = '0;
    logic [2:0]    sidx_b = '0;
    logic          scs_d_b = 1'b0;
    logic          ssclk_d_b = 1'b0;
    always @(posedge clk) begin
        if (cs_b && !scs_d_b) begin
            smiso_b <= reply[0];
            sidx_b  <= 3'd1;
        end else if (cs_b && ssclk_d_b && !sclk_b) begin
            smiso_b <= reply[sidx_b];
            sidx_b  <= sidx_b + 3'd1;
        end
        if (cs_b && sclk_b && !ssclk_d_b) slave_rx.push_back(mosi_b);
        scs_d_b   <= cs_b;
        ssclk_d_b <= sclk_b;
    end
    assign miso_b = cs_b ? smiso_b : 'z;

    int   cyc = 0;
    int   cs_falls = 0;
    int   cs_high = 0;
    logic prev_cs = 1'b0;
    always @(posedge clk) begin
        if (cur_rxv) begin
            rx_q.push_back(cur_data);
            rx_cyc.push_back(cyc);
        end
        if (cur_cs) cs_high <= cs_high + 1;
        if (prev_cs && !cur_cs) cs_falls <= cs_falls + 1;
        prev_cs <= cur_cs;
        cyc     <= cyc + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (cur_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cur_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", tag, cur_busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic drive_words(input int n, input string tag);
        int i;
        int c;
        i = 0;
        c = 0;
        while (i < n && c < 400) begin
            @(negedge clk);
            c++;
            host_valid = 1'b1;
            host_data  = tx[i];
            if (cur_ready) i++;
        end
        @(negedge clk);
        host_valid = 1'b0;
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL %s_accept: accepted %0d words, required %0d", tag, i, n);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        use_hp2    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cs_a, sclk_a, rxv_a, busy_a} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: cs/sclk/rxv/busy=%b required 0000", {cs_a, sclk_a, rxv_a, busy_a});
        end
        checks++;
        if (mosi_a !== '0) begin
            failures++;
            $display("FAIL reset_mosi: got %h required 0", mosi_a);
        end
        checks++;
        if (data_a !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h required 0", data_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after_release: got %b required 1", ready_a);
        end
    endtask

    task automatic test_single();
        logic [15:0] tr_cs, tr_sclk, tr_rxv, tr_rdy;
        int base_rx, base_s;
        reply[0] = 32'h1234_5678;
        base_rx  = rx_q.size();
        base_s   = slave_rx.size();
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = 32'hA5A5_0001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                host_valid = 1'b0;
                checks++;
                if (cur_mosi !== 32'hA5A5_0001) begin
                    failures++;
                    $display("FAIL single_mosi_at_cs: got %h required a5a50001", cur_mosi);
                end
            end
            tr_cs[k-1]   = cur_cs;
            tr_sclk[k-1] = cur_sclk;
            tr_rxv[k-1]  = cur_rxv;
            tr_rdy[k-1]  = cur_ready;
        end
        checks++;
        if (tr_cs !== 16'h0FFF) begin
            failures++;
            $display("FAIL single_cs_trace: got %h required 0fff", tr_cs);
        end
        checks++;
        if (tr_sclk !== 16'h00F0) begin
            failures++;
            $display("FAIL single_sclk_trace: got %h required 00f0", tr_sclk);
        end
        checks++;
        if (tr_rxv !== 16'h0010) begin
            failures++;
            $display("FAIL single_rxv_trace: got %h required 0010", tr_rxv);
        end
        checks++;
        if (tr_rdy !== 16'hF0F0) begin
            failures++;
            $display("FAIL single_ready_trace: got %h required f0f0", tr_rdy);
        end
        checks++;
        if (cur_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL single_master_rx: got %h required 12345678", cur_data);
        end
        checks++;
        if (slave_rx.size() != base_s + 1 || slave_rx[slave_rx.size()-1] !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL single_slave_rx: count %0d last %h required 1 word a5a50001",
                     slave_rx.size() - base_s, slave_rx[slave_rx.size()-1]);
        end
        checks++;
        if (rx_q.size() != base_rx + 1) begin
            failures++;
            $display("FAIL single_rx_pulses: got %0d required 1", rx_q.size() - base_rx);
        end
        wait_idle("single");
    endtask

    task automatic test_burst();
        int base_rx, base_s, base_falls, base_high;
        logic [NB-1:0] got;
        int gap;
        tx[0] = 32'h0000_0001; tx[1] = 32'h0000_0002; tx[2] = 32'h0000_0003;
        reply[0] = 32'hCAFE_0000; reply[1] = 32'hCAFE_0001; reply[2] = 32'hCAFE_0002;
        base_rx = rx_q.size(); base_s = slave_rx.size();
        base_falls = cs_falls; base_high = cs_high;
        drive_words(3, "burst");
        wait_idle("burst");
        checks++;
        if (cs_falls - base_falls != 1) begin
            failures++;
            $display("FAIL burst_cs_falls: got %0d required 1", cs_falls - base_falls);
        end
        checks++;
        if (cs_high - base_high != 28) begin
            failures++;
            $display("FAIL burst_cs_high_cycles: got %0d required 28", cs_high - base_high);
        end
        checks++;
        if (rx_q.size() != base_rx + 3) begin
            failures++;
            $display("FAIL burst_rx_pulses: got %0d required 3", rx_q.size() - base_rx);
        end
        for (int i = 0; i < 3; i++) begin
            got = (rx_q.size() > base_rx + i) ? rx_q[base_rx + i] : 'x;
            checks++;
            if (got !== reply[i]) begin
                failures++;
                $display("FAIL burst_master_rx%0d: got %h required %h", i, got, reply[i]);
            end
            got = (slave_rx.size() > base_s + i) ? slave_rx[base_s + i] : 'x;
            checks++;
            if (got !== tx[i]) begin
                failures++;
                $display("FAIL burst_slave_rx%0d: got %h required %h", i, got, tx[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            gap = (rx_cyc.size() > base_rx + i) ? rx_cyc[base_rx + i] - rx_cyc[base_rx + i - 1] : -1;
            checks++;
            if (gap != 8) begin
                failures++;
                $display("FAIL burst_rx_spacing%0d: got %0d required 8", i, gap);
            end
        end
    endtask

    task automatic test_late_offer();
        logic [23:0] tr_cs, tr_sclk, tr_rxv;
        int base_s;
        logic [NB-1:0] got;
        reply[0] = 32'h0BAD_0000; reply[1] = 32'h0BAD_0001;
        base_s = slave_rx.size();
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = 32'h1111_AAAA;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) host_valid = 1'b0;
            tr_cs[k-1]   = cur_cs;
            tr_sclk[k-1] = cur_sclk;
            tr_rxv[k-1]  = cur_rxv;
            if (k == 8) begin
                checks++;
                if (cur_ready !== 1'b1 || cur_mosi !== 32'h1111_AAAA) begin
                    failures++;
                    $display("FAIL late_last_high: ready=%b mosi=%h required 1 1111aaaa", cur_ready, cur_mosi);
                end
                host_valid = 1'b1;
                host_data  = 32'h2222_BBBB;
            end
            if (k == 9) begin
                host_valid = 1'b0;
                checks++;
                if (cur_mosi !== 32'h2222_BBBB) begin
                    failures++;
                    $display("FAIL late_mosi_at_fall: got %h required 2222bbbb", cur_mosi);
                end
            end
        end
        checks++;
        if (tr_cs !== 24'h0F_FFFF) begin
            failures++;
            $display("FAIL late_cs_trace: got %h required 0fffff", tr_cs);
        end
        checks++;
        if (tr_sclk !== 24'h00_F0F0) begin
            failures++;
            $display("FAIL late_sclk_trace: got %h required 00f0f0", tr_sclk);
        end
        checks++;
        if (tr_rxv !== 24'h00_1010) begin
            failures++;
            $display("FAIL late_rxv_trace: got %h required 001010", tr_rxv);
        end
        got = (slave_rx.size() > base_s + 1) ? slave_rx[base_s + 1] : 'x;
        checks++;
        if (got !== 32'h2222_BBBB || cur_data !== 32'h0BAD_0001) begin
            failures++;
            $display("FAIL late_exchange: slave %h master %h required 2222bbbb 0bad0001", got, cur_data);
        end
        wait_idle("late");
    endtask

    task automatic test_backpressure();
        logic [17:0] tr_cs, tr_rdy;
        int base_s, base_falls;
        logic [NB-1:0] got;
        reply[0] = 32'h7777_0000; reply[1] = 32'h7777_0001;
        base_s = slave_rx.size();
        base_falls = cs_falls;
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = 32'h3333_0003;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) host_valid = 1'b0;
            tr_cs[k-1]  = cur_cs;
            tr_rdy[k-1] = cur_ready;
            if (k == 9) begin
                host_valid = 1'b1;
                host_data  = 32'h4444_0004;
            end
            if (k == 12) begin
                checks++;
                if (cur_mosi !== 32'h3333_0003) begin
                    failures++;
                    $display("FAIL bp_mosi_in_hold: got %h required 33330003", cur_mosi);
                end
            end
            if (k == 14) begin
                host_valid = 1'b0;
                checks++;
                if (cur_mosi !== 32'h4444_0004) begin
                    failures++;
                    $display("FAIL bp_mosi_after_gap: got %h required 44440004", cur_mosi);
                end
            end
        end
        checks++;
        if (tr_rdy !== 18'h210F0) begin
            failures++;
            $display("FAIL bp_ready_trace: got %h required 210f0", tr_rdy);
        end
        checks++;
        if (tr_cs !== 18'h3EFFF) begin
            failures++;
            $display("FAIL bp_cs_trace: got %h required 3efff", tr_cs);
        end
        wait_idle("bp");
        got = (slave_rx.size() > base_s + 1) ? slave_rx[base_s + 1] : 'x;
        checks++;
        if (slave_rx.size() != base_s + 2 || got !== 32'h4444_0004) begin
            failures++;
            $display("FAIL bp_slave_rx: count %0d second %h required 2 44440004", slave_rx.size() - base_s, got);
        end
        checks++;
        if (cs_falls - base_falls != 2) begin
            failures++;
            $display("FAIL bp_cs_falls: got %0d required 2", cs_falls - base_falls);
        end
    endtask

    task automatic test_reset_mid_burst();
        int base_rx;
        reply[0] = 32'h9999_0000; reply[1] = 32'h9999_0001;
        base_rx = rx_q.size();
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = 32'h5555_0005;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) host_valid = 1'b0;
            if (k == 5) begin
                host_valid = 1'b1;
                host_data  = 32'h6666_0006;
            end
            if (k == 6) host_valid = 1'b0;
        end
        checks++;
        if (cur_sclk !== 1'b1 || rx_q.size() != base_rx + 2) begin
            failures++;
            $display("FAIL rst_pre_state: sclk=%b pulses=%0d required 1 2", cur_sclk, rx_q.size() - base_rx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_a, sclk_a, rxv_a, busy_a} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_async_ctrl: cs/sclk/rxv/busy=%b required 0000", {cs_a, sclk_a, rxv_a, busy_a});
        end
        checks++;
        if (mosi_a !== '0 || data_a !== '0) begin
            failures++;
            $display("FAIL rst_async_data: mosi=%h data=%h required 0 0", mosi_a, data_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0 || cs_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_release: ready=%b busy=%b cs=%b required 1 0 0", ready_a, busy_a, cs_a);
        end
        checks++;
        if (rx_q.size() != base_rx + 2) begin
            failures++;
            $display("FAIL rst_no_partial_rx: got %0d pulses required 2", rx_q.size() - base_rx);
        end
    endtask

    task automatic test_hp2();
        int base_rx, base_s, base_falls, base_high, gap;
        logic [NB-1:0] got;
        @(negedge clk);
        use_hp2 = 1'b1;
        tx[0] = 32'h1111_0001; tx[1] = 32'h2222_0002;
        reply[0] = 32'hCAFE_0010; reply[1] = 32'hCAFE_0011;
        base_rx = rx_q.size(); base_s = slave_rx.size();
        base_falls = cs_falls; base_high = cs_high;
        drive_words(2, "hp2");
        wait_idle("hp2");
        for (int i = 0; i < 2; i++) begin
            got = (rx_q.size() > base_rx + i) ? rx_q[base_rx + i] : 'x;
            checks++;
            if (got !== reply[i]) begin
                failures++;
                $display("FAIL hp2_master_rx%0d: got %h required %h", i, got, reply[i]);
            end
            got = (slave_rx.size() > base_s + i) ? slave_rx[base_s + i] : 'x;
            checks++;
            if (got !== tx[i]) begin
                failures++;
                $display("FAIL hp2_slave_rx%0d: got %h required %h", i, got, tx[i]);
            end
        end
        gap = (rx_cyc.size() > base_rx + 1) ? rx_cyc[base_rx + 1] - rx_cyc[base_rx] : -1;
        checks++;
        if (gap != 4) begin
            failures++;
            $display("FAIL hp2_rx_spacing: got %0d required 4", gap);
        end
        checks++;
        if (cs_falls - base_falls != 1 || cs_high - base_high != 10) begin
            failures++;
            $display("FAIL hp2_cs: falls=%0d high=%0d required 1 10", cs_falls - base_falls, cs_high - base_high);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_late_offer();
        test_backpressure();
        test_reset_mid_burst();
        test_hp2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
